// File: rtl/fp_adder.sv
// Signed fixed-point adder with format alignment and saturation.
// Adds two Q(W_in-W_in_F).W_in_F operands exactly, re-aligns the binary
// point to the output format (zero-fill left shift or truncating arithmetic
// right shift), clamps to the output range and registers the result together
// with the overflow/underflow flags. One clock of latency, no stall.
module fp_adder #(
  parameter int W_in    = 16,
  parameter int W_in_F  = 14,
  parameter int W_out   = 16,
  parameter int W_out_F = 14
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [W_in-1:0]  a,
  input  logic signed [W_in-1:0]  b,
  output logic signed [W_out-1:0] sum,
  output logic                    overflow,
  output logic                    underflow
);

  // Shift needed to move the binary point from input to output position.
  localparam int SHL = (W_out_F >= W_in_F) ? (W_out_F - W_in_F) : 0;
  localparam int SHR = (W_out_F >= W_in_F) ? 0 : (W_in_F - W_out_F);

  // Intermediate width: holds the left-shifted exact sum and the output
  // limits with one spare bit, so neither the shift nor the limit
  // comparisons can wrap.
  localparam int WA = W_in + 1 + SHL;
  localparam int WW = ((WA > W_out) ? WA : W_out) + 1;

  typedef struct packed {
    logic signed [W_out-1:0] val;
    logic                    ovf;
    logic                    unf;
  } sat_t;

  // Clamp an aligned wide value to the output range and flag which side hit.
  function automatic sat_t saturate(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] max_v;
    logic signed [WW-1:0] min_v;
    sat_t                 r;
    max_v              = '0;
    max_v[W_out-2:0]   = '1;
    min_v              = '1;
    min_v[W_out-2:0]   = '0;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (v > max_v) begin
      r.val = max_v[W_out-1:0];
      r.ovf = 1'b1;
    end else if (v < min_v) begin
      r.val = min_v[W_out-1:0];
      r.unf = 1'b1;
    end else begin
      r.val = v[W_out-1:0];
    end
    return r;
  endfunction

  logic signed [W_in:0]    exact;
  logic signed [WW-1:0]    wide;
  logic signed [WW-1:0]    aligned;
  sat_t                    sat_d;

  logic signed [W_out-1:0] sum_q;
  logic                    ovf_q;
  logic                    unf_q;

  // Exact sum, binary-point alignment and saturation of the current operands.
  always_comb begin
    exact   = $signed({a[W_in-1], a}) + $signed({b[W_in-1], b});
    wide    = WW'(exact);
    aligned = (wide <<< SHL) >>> SHR;
    sat_d   = saturate(aligned);
  end

  // ---- stage boundary: result and flags registered together ----
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sum_q <= sat_d.val;
      ovf_q <= sat_d.ovf;
      unf_q <= sat_d.unf;
    end
  end

  assign sum       = sum_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fp_adder.sv
// Directed bench for fp_adder: default Q2.14 -> Q2.14 instance plus a
// Q2.14 -> Q4.12 instance sharing the same operands.
module tb_fp_adder;

  logic               clk;
  logic               reset;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic signed [15:0] sum;
  logic               overflow;
  logic               underflow;
  logic signed [15:0] sum2;
  logic               overflow2;
  logic               underflow2;

  int errors = 0;
  int checks = 0;

  fp_adder dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .overflow  (overflow),
    .underflow (underflow)
  );

  fp_adder #(.W_in(16), .W_in_F(14), .W_out(16), .W_out_F(12)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .sum       (sum2),
    .overflow  (overflow2),
    .underflow (underflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands mid-cycle, let one rising edge sample them, settle 1 time unit.
  task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic r);
    @(negedge clk);
    a     = va;
    b     = vb;
    reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] es, input logic eo, input logic eu);
    checks++;
    assert (sum === es) else begin
      errors++;
      $error("FAIL %s sum: observed=%h expected=%h", tag, sum, es);
    end
    checks++;
    assert (overflow === eo) else begin
      errors++;
      $error("FAIL %s overflow: observed=%b expected=%b", tag, overflow, eo);
    end
    checks++;
    assert (underflow === eu) else begin
      errors++;
      $error("FAIL %s underflow: observed=%b expected=%b", tag, underflow, eu);
    end
    checks++;
    assert (!(overflow === 1'b1 && underflow === 1'b1)) else begin
      errors++;
      $error("FAIL %s both_flags: observed=%b%b expected=not 11", tag, overflow, underflow);
    end
  endtask

  task automatic chk2(input string tag, input logic [15:0] es, input logic eo, input logic eu);
    checks++;
    assert ({sum2, overflow2, underflow2} === {es, eo, eu}) else begin
      errors++;
      $error("FAIL %s cfg2: observed=%h/%b%b expected=%h/%b%b",
             tag, sum2, overflow2, underflow2, es, eo, eu);
    end
  endtask

  initial begin
    a     = '0;
    b     = '0;
    reset = 1'b1;

    // Reset state
    step(16'h0000, 16'h0000, 1'b1);
    chk("reset", 16'h0000, 1'b0, 1'b0);
    chk2("reset", 16'h0000, 1'b0, 1'b0);

    // In-range sums, back to back on consecutive edges
    step(16'h2000, 16'h9000, 1'b0);
    chk("p5_m1p75", 16'hB000, 1'b0, 1'b0);
    step(16'h5555, 16'h9000, 1'b0);
    chk("5555_9000", 16'hE555, 1'b0, 1'b0);
    step(16'h7777, 16'h8887, 1'b0);
    chk("7777_8887", 16'hFFFE, 1'b0, 1'b0);

    // Negative saturation
    step(16'h9000, 16'hD000, 1'b0);
    chk("under1", 16'h8000, 1'b0, 1'b1);
    step(16'hF777, 16'h8001, 1'b0);
    chk("under2", 16'h8000, 1'b0, 1'b1);

    // Positive saturation, then straight back to an in-range value
    step(16'h5555, 16'h4000, 1'b0);
    chk("over1", 16'h7FFF, 1'b1, 1'b0);
    step(16'h7079, 16'h7078, 1'b0);
    chk("over2", 16'h7FFF, 1'b1, 1'b0);
    step(16'h5555, 16'h2000, 1'b0);
    chk("5555_2000", 16'h7555, 1'b0, 1'b0);
    chk2("5555_2000", 16'h1D55, 1'b0, 1'b0);

    // Output holds through the rest of the cycle
    @(negedge clk);
    chk("hold", 16'h7555, 1'b0, 1'b0);

    // Exact boundaries pass unflagged
    step(16'h4000, 16'h3FFF, 1'b0);
    chk("max_edge", 16'h7FFF, 1'b0, 1'b0);
    chk2("max_edge", 16'h1FFF, 1'b0, 1'b0);
    step(16'hC000, 16'hC000, 1'b0);
    chk("min_edge", 16'h8000, 1'b0, 1'b0);
    step(16'h8000, 16'h8000, 1'b0);
    chk("min_min", 16'h8000, 1'b0, 1'b1);
    chk2("min_min", 16'hC000, 1'b0, 1'b0);

    // Truncation toward negative infinity in the narrower format
    step(16'hFFFF, 16'h0000, 1'b0);
    chk("neg_lsb", 16'hFFFF, 1'b0, 1'b0);
    chk2("neg_lsb", 16'hFFFF, 1'b0, 1'b0);

    // Reset mid-stream discards the sampled operands, even when saturating
    step(16'h5555, 16'h4000, 1'b0);
    chk("pre_reset", 16'h7FFF, 1'b1, 1'b0);
    step(16'h5555, 16'h4000, 1'b1);
    chk("mid_reset", 16'h0000, 1'b0, 1'b0);
    chk2("mid_reset", 16'h0000, 1'b0, 1'b0);

    // First edge out of reset registers the operands present there
    step(16'h2000, 16'h9000, 1'b0);
    chk("post_reset", 16'hB000, 1'b0, 1'b0);
    step(16'h1234, 16'h0001, 1'b0);
    chk("small", 16'h1235, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
